// File: rtl/radix4_ntt_pipe_if.sv
`default_nettype none
// ============================================================================
// radix4_ntt_pipe_if : beat-level handshake and data bus for the butterfly
// Rev 1.0
// ============================================================================
interface radix4_ntt_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [WIDTH-1:0] a0, a1, a2, a3;
  logic [WIDTH-1:0] t1, t2, t3;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y0, y1, y2, y3;

  modport master (
    output in_valid, mode, a0, a1, a2, a3, t1, t2, t3, out_ready,
    input  in_ready, out_valid, y0, y1, y2, y3
  );

  modport slave (
    input  in_valid, mode, a0, a1, a2, a3, t1, t2, t3, out_ready,
    output in_ready, out_valid, y0, y1, y2, y3
  );
endinterface
`default_nettype wire

// File: rtl/radix4_ntt_pipe.sv
`default_nettype none
// ============================================================================
// radix4_ntt_pipe : pipelined radix-4 NTT/INTT butterfly, exact arithmetic mod Q
// Rev 1.0
// ============================================================================
module radix4_ntt_pipe #(
  parameter int WIDTH = 16,
  parameter int Q     = 12289,
  parameter int W4    = 1479
) (
  input  logic              clk,
  input  logic              rst_n,
  radix4_ntt_pipe_if.slave  bus
);
  localparam int               PW     = 2 * WIDTH;
  localparam logic [WIDTH-1:0] Q_W    = WIDTH'(Q);
  localparam logic [PW-1:0]    Q_PW   = PW'(Q);
  localparam logic [WIDTH-1:0] W_NTT  = WIDTH'(W4);
  localparam logic [WIDTH-1:0] W_INTT = WIDTH'(Q - W4);

  function automatic logic [WIDTH-1:0] red_in(input logic [WIDTH-1:0] x);
    return x % Q_W;
  endfunction

  function automatic logic [WIDTH-1:0] mul_mod(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [PW-1:0] p;
    p = PW'(x) * PW'(y);
    return WIDTH'(p % Q_PW);
  endfunction

  // Operands are in [0, Q], so one conditional subtract brings the sum into range.
  function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= {1'b0, Q_W}) ? WIDTH'(s - {1'b0, Q_W}) : WIDTH'(s);
  endfunction

  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    return add_mod(x, Q_W - y);
  endfunction

  logic                  w_en;
  logic                  r0_valid, r1_valid, r2_valid, r3_valid, r_out_valid;
  logic                  r0_mode, r1_mode, r2_mode, r3_mode;
  logic [3:0][WIDTH-1:0] r0_a, r1_c, r2_c, r3_z, r_y;
  logic [3:1][WIDTH-1:0] r0_t, r1_t, r2_t, r3_t;
  logic [WIDTH-1:0]      r2_p1, r2_p3;
  logic [3:0][WIDTH-1:0] w_c, w_z, w_y;
  logic [WIDTH-1:0]      w_w, w_p1, w_p3;

  assign w_en         = !r_out_valid || bus.out_ready;
  assign bus.in_ready = w_en;

  // S1: entry reduction, with the twiddle pre-multiply on NTT beats.
  always_comb begin
    w_c[0] = red_in(r0_a[0]);
    for (int k = 1; k < 4; k++)
      w_c[k] = r0_mode ? red_in(r0_a[k]) : mul_mod(r0_a[k], r0_t[k]);
  end

  // S2: rotations by the 4th root of unity (its inverse for INTT).
  assign w_w  = r1_mode ? W_INTT : W_NTT;
  assign w_p1 = mul_mod(w_w, r1_c[1]);
  assign w_p3 = mul_mod(w_w, r1_c[3]);

  // S3: add/sub network.
  always_comb begin
    w_z[0] = add_mod(add_mod(r2_c[0], r2_c[1]), add_mod(r2_c[2], r2_c[3]));
    w_z[1] = sub_mod(add_mod(r2_c[0], r2_p1), add_mod(r2_c[2], r2_p3));
    w_z[2] = sub_mod(add_mod(r2_c[0], r2_c[2]), add_mod(r2_c[1], r2_c[3]));
    w_z[3] = sub_mod(add_mod(r2_c[0], r2_p3), add_mod(r2_c[2], r2_p1));
  end

  // S4: post-multiply on INTT beats.
  always_comb begin
    w_y[0] = r3_z[0];
    for (int k = 1; k < 4; k++)
      w_y[k] = r3_mode ? mul_mod(r3_z[k], r3_t[k]) : r3_z[k];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r0_valid    <= 1'b0;
      r1_valid    <= 1'b0;
      r2_valid    <= 1'b0;
      r3_valid    <= 1'b0;
      r_out_valid <= 1'b0;
      r_y         <= '0;
    end else if (w_en) begin
      r0_valid    <= bus.in_valid;
      r1_valid    <= r0_valid;
      r2_valid    <= r1_valid;
      r3_valid    <= r2_valid;
      r_out_valid <= r3_valid;
      if (r3_valid)
        r_y <= w_y;
    end
  end

  // The raw beat is captured first so the reduction multipliers start from a register.
  always_ff @(posedge clk) begin
    if (w_en) begin
      if (bus.in_valid) begin
        r0_mode <= bus.mode;
        r0_a    <= {bus.a3, bus.a2, bus.a1, bus.a0};
        r0_t    <= {bus.t3, bus.t2, bus.t1};
      end
      if (r0_valid) begin
        r1_mode <= r0_mode;
        r1_c    <= w_c;
        r1_t    <= r0_t;
      end
      if (r1_valid) begin
        r2_mode <= r1_mode;
        r2_c    <= r1_c;
        r2_p1   <= w_p1;
        r2_p3   <= w_p3;
        r2_t    <= r1_t;
      end
      if (r2_valid) begin
        r3_mode <= r2_mode;
        r3_z    <= w_z;
        r3_t    <= r2_t;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.y0        = r_y[0];
  assign bus.y1        = r_y[1];
  assign bus.y2        = r_y[2];
  assign bus.y3        = r_y[3];
endmodule
`default_nettype wire

// File: tb/tb_radix4_ntt_pipe.sv
`default_nettype none
// ============================================================================
// tb_radix4_ntt_pipe : directed and model-checked bench for radix4_ntt_pipe
// Rev 1.0
// ============================================================================
module tb_radix4_ntt_pipe;
  localparam int WIDTH = 16;
  localparam int Q     = 12289;
  localparam int W4    = 1479;

  typedef logic [3:0][WIDTH-1:0] vec4_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  radix4_ntt_pipe_if #(.WIDTH(WIDTH)) bus ();

  radix4_ntt_pipe #(.WIDTH(WIDTH), .Q(Q), .W4(W4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic vec4_t mk(input int x0, input int x1, input int x2, input int x3);
    return {16'(x3), 16'(x2), 16'(x1), 16'(x0)};
  endfunction

  function automatic longint md(input longint x);
    return ((x % Q) + Q) % Q;
  endfunction

  function automatic vec4_t ref_bfly(input logic m, input vec4_t a, input vec4_t t);
    longint c[4];
    longint z[4];
    longint w;
    vec4_t  y;
    w    = m ? longint'(Q - W4) : longint'(W4);
    c[0] = md(longint'(a[0]));
    for (int k = 1; k < 4; k++)
      c[k] = m ? md(longint'(a[k])) : md(longint'(a[k]) * longint'(t[k]));
    z[0] = md(c[0] + c[1] + c[2] + c[3]);
    z[1] = md(c[0] + w * c[1] - c[2] - w * c[3]);
    z[2] = md(c[0] - c[1] + c[2] - c[3]);
    z[3] = md(c[0] - w * c[1] - c[2] + w * c[3]);
    for (int k = 0; k < 4; k++)
      y[k] = (m && k > 0) ? 16'(md(z[k] * longint'(t[k]))) : 16'(z[k]);
    return y;
  endfunction

  function automatic vec4_t cur_y();
    return {bus.y3, bus.y2, bus.y1, bus.y0};
  endfunction

  function automatic string fmt(input vec4_t v);
    return $sformatf("(%0d,%0d,%0d,%0d)", v[0], v[1], v[2], v[3]);
  endfunction

  task automatic drive(input logic v, input logic m, input vec4_t a, input vec4_t t);
    bus.in_valid = v;
    bus.mode     = m;
    bus.a0 = a[0]; bus.a1 = a[1]; bus.a2 = a[2]; bus.a3 = a[3];
    bus.t1 = t[1]; bus.t2 = t[2]; bus.t3 = t[3];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    step();
    step();
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    n_checks++;
    if (cur_y() !== '0) begin
      n_fail++; $display("FAIL reset_y: got %s want (0,0,0,0)", fmt(cur_y()));
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready);
    end
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0 || cur_y() !== '0) begin
      n_fail++; $display("FAIL idle_after_reset: valid=%b y=%s want valid=0 y=(0,0,0,0)",
                         bus.out_valid, fmt(cur_y()));
    end
  endtask

  task automatic test_ntt_unit();
    vec4_t exp_y = mk(10, 9329, 12287, 2956);
    drive(1'b1, 1'b0, mk(1, 2, 3, 4), mk(0, 1, 1, 1));
    step();
    drive(1'b0, 1'b0, '0, '0);
    for (int i = 1; i <= 5; i++) begin
      step();
      n_checks++;
      if (i == 4) begin
        if (bus.out_valid !== 1'b1 || cur_y() !== exp_y) begin
          n_fail++; $display("FAIL ntt_unit: valid=%b y=%s want valid=1 y=%s",
                             bus.out_valid, fmt(cur_y()), fmt(exp_y));
        end
      end else if (bus.out_valid !== 1'b0) begin
        n_fail++; $display("FAIL ntt_unit_timing cycle %0d: valid=%b want 0", i, bus.out_valid);
      end
    end
  endtask

  task automatic test_intt_roundtrip();
    vec4_t exp_y = mk(4, 8, 12, 16);
    drive(1'b1, 1'b1, mk(10, 9329, 12287, 2956), mk(0, 1, 1, 1));
    step();
    drive(1'b0, 1'b0, '0, '0);
    for (int i = 1; i <= 5; i++) begin
      step();
      n_checks++;
      if (i == 4) begin
        if (bus.out_valid !== 1'b1 || cur_y() !== exp_y) begin
          n_fail++; $display("FAIL intt_roundtrip: valid=%b y=%s want valid=1 y=%s",
                             bus.out_valid, fmt(cur_y()), fmt(exp_y));
        end
      end else if (bus.out_valid !== 1'b0) begin
        n_fail++; $display("FAIL intt_timing cycle %0d: valid=%b want 0", i, bus.out_valid);
      end
    end
  endtask

  task automatic test_twiddle_range();
    vec4_t exp_y = mk(12287, 9331, 2, 2958);
    drive(1'b1, 1'b0, mk(0, 12288, 0, 0), mk(0, 2, 1, 1));
    step();
    drive(1'b0, 1'b0, '0, '0);
    for (int i = 1; i <= 5; i++) begin
      step();
      n_checks++;
      if (i == 4) begin
        if (bus.out_valid !== 1'b1 || cur_y() !== exp_y) begin
          n_fail++; $display("FAIL twiddle_range: valid=%b y=%s want valid=1 y=%s",
                             bus.out_valid, fmt(cur_y()), fmt(exp_y));
        end
      end else if (bus.out_valid !== 1'b0) begin
        n_fail++; $display("FAIL twiddle_timing cycle %0d: valid=%b want 0", i, bus.out_valid);
      end
    end
  endtask

  task automatic test_random_stream();
    vec4_t q[$];
    vec4_t a, t, e;
    logic  m;
    int    first = -1, last = -1, got = 0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 1012; k++) begin
      if (k < 1000) begin
        a = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
        t = {16'($urandom), 16'($urandom), 16'($urandom), 16'd0};
        m = 1'($urandom_range(0, 1));
        drive(1'b1, m, a, t);
      end else begin
        drive(1'b0, 1'b0, '0, '0);
      end
      #1;
      if (bus.in_valid && bus.in_ready) q.push_back(ref_bfly(m, a, t));
      step();
      if (bus.out_valid) begin
        if (first < 0) first = k;
        last = k;
        got++;
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL random_extra: unexpected beat y=%s at cycle %0d", fmt(cur_y()), k);
        end else begin
          e = q.pop_front();
          if (cur_y() !== e) begin
            n_fail++; $display("FAIL random_beat %0d: got %s want %s", got - 1, fmt(cur_y()), fmt(e));
          end
        end
      end
    end
    n_checks++;
    if (got != 1000) begin
      n_fail++; $display("FAIL random_count: got %0d beats want 1000", got);
    end
    n_checks++;
    if (first != 4) begin
      n_fail++; $display("FAIL random_latency: first output after edge %0d want 4", first);
    end
    n_checks++;
    if (last - first != 999) begin
      n_fail++; $display("FAIL random_throughput: output span %0d cycles want 999", last - first);
    end
  endtask

  task automatic test_backpressure();
    vec4_t q[$];
    vec4_t ba[8], bt[8];
    logic  bm[8];
    vec4_t snap, e;
    int    idx = 0, got = 0;
    for (int i = 0; i < 8; i++) begin
      ba[i] = mk(1000 * i + 7, 65535 - 3 * i, 12289 + i, 4 * i);
      bt[i] = mk(0, i + 2, 12288 - i, 40000 + i);
      bm[i] = 1'(i % 2);
    end
    for (int k = 0; k < 40; k++) begin
      bus.out_ready = !(k >= 6 && k <= 8);
      if (idx < 8) drive(1'b1, bm[idx], ba[idx], bt[idx]);
      else         drive(1'b0, 1'b0, '0, '0);
      #1;
      if (k >= 6 && k <= 8) begin
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
          n_fail++; $display("FAIL bp_in_ready cycle %0d: got %b want 0", k, bus.in_ready);
        end
        n_checks++;
        if (k == 6) begin
          snap = cur_y();
          if (bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_full: out_valid=%b want 1 at stall start", bus.out_valid);
          end
        end else if (bus.out_valid !== 1'b1 || cur_y() !== snap) begin
          n_fail++; $display("FAIL bp_frozen cycle %0d: valid=%b y=%s want valid=1 y=%s",
                             k, bus.out_valid, fmt(cur_y()), fmt(snap));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(ref_bfly(bm[idx], ba[idx], bt[idx]));
        idx++;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        got++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL bp_extra: unexpected beat y=%s", fmt(cur_y()));
        end else begin
          e = q.pop_front();
          if (cur_y() !== e) begin
            n_fail++; $display("FAIL bp_beat %0d: got %s want %s", got - 1, fmt(cur_y()), fmt(e));
          end
        end
      end
      step();
    end
    n_checks++;
    if (got != 8 || q.size() != 0) begin
      n_fail++; $display("FAIL bp_count: got %0d beats, %0d pending, want 8 and 0", got, q.size());
    end
  endtask

  task automatic test_reset_midstream();
    vec4_t exp_y = mk(4, 8, 12, 16);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'(k % 2), mk(100 + k, 200 + k, 300, 400), mk(0, 5, 6, 7));
      step();
    end
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_prefill: out_valid=%b want 1", bus.out_valid);
    end
    drive(1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_in_ready: got %b want 1", bus.in_ready);
    end
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0 || cur_y() !== '0) begin
      n_fail++; $display("FAIL mid_reset_clear: valid=%b y=%s want valid=0 y=(0,0,0,0)",
                         bus.out_valid, fmt(cur_y()));
    end
    rst_n = 1'b1;
    drive(1'b1, 1'b1, mk(10, 9329, 12287, 2956), mk(0, 1, 1, 1));
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_first_accept: in_ready=%b want 1", bus.in_ready);
    end
    step();
    drive(1'b0, 1'b0, '0, '0);
    for (int i = 1; i <= 8; i++) begin
      step();
      n_checks++;
      if (i == 4) begin
        if (bus.out_valid !== 1'b1 || cur_y() !== exp_y) begin
          n_fail++; $display("FAIL mid_new_beat: valid=%b y=%s want valid=1 y=%s",
                             bus.out_valid, fmt(cur_y()), fmt(exp_y));
        end
      end else if (bus.out_valid !== 1'b0) begin
        n_fail++; $display("FAIL mid_stale cycle %0d: valid=%b y=%s want valid=0",
                           i, bus.out_valid, fmt(cur_y()));
      end
    end
  endtask

  initial begin
    bus.out_ready = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    test_reset();
    test_ntt_unit();
    test_intt_roundtrip();
    test_twiddle_range();
    test_random_stream();
    test_backpressure();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
